// File: rtl/uart_pkg.sv
// Shared UART definitions: read-FSM encoding, default FIFO depth and
// baud-rate divisor constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } rd_state_t;

  localparam int FIFO_DEPTH = 16;

  localparam int CLK_HZ     = 12_000_000;
  localparam int BAUD       = 115_200;
  localparam int BAUD_DIV   = CLK_HZ / BAUD;
  localparam int BAUD_DIV16 = CLK_HZ / (BAUD * 16);

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x 8 byte RAM: one synchronous write port, one registered
// read port, so it maps onto a single block RAM.
module fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [7:0]    rd
);

  logic [7:0] mem [DEPTH];

  // read-before-write: a pop from a full FIFO sees the old byte
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO from uart_rx into the uart_tx start/ready handshake.
// Define UART_RX_FIFO_OVFCNT_EN to add the ovf_cnt dropped-byte counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rcv,
  input  logic [7:0]    data_in,
  input  logic          tx_ready,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
`ifdef UART_RX_FIFO_OVFCNT_EN
  output logic          overflow,
  output logic [7:0]    ovf_cnt
`else
  output logic          overflow
`endif
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  rd_state_t     state;
  rd_state_t     state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;
  logic          pop;
  logic          push;
  logic          drop;
  logic          loaded;
  logic [7:0]    rd_q;

  assign pop  = (state == IDLE) && !empty && tx_ready;
  assign push = rcv && (!full || pop);
  assign drop = rcv && full && !pop;

  fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk (clk),
    .we  (push),
    .wa  (wr_ptr),
    .wd  (data_in),
    .re  (pop),
    .ra  (rd_ptr),
    .rd  (rd_q)
  );

  // RAM output has no reset; hide it until the first pop
  assign tx_data = loaded ? rd_q : 8'h00;

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      push && !pop: count_nxt = count + 1'b1;
      pop && !push: count_nxt = count - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      loaded   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) loaded <= 1'b1;
      if (drop) overflow <= 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    unique case (state)
      IDLE:      if (pop) state_nxt = START;
      START: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: if (!tx_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_OVFCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_cnt <= 8'h00;
    else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'h01;
  end
`else
  // overflow is the only loss indication in this build
`endif

endmodule
